// File: rtl/io_responder.sv
// io_responder: device side of the processor IN/OUT handshake.
// Input requests collect switch nibbles one debounced key press at a time.
// Output requests latch a 32-bit value and show it on eight seven-segment digits.
module io_responder #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned IN_NIBBLES      = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        in_req,
   input  logic        out_req,
   input  logic [31:0] out_data,
   input  logic [3:0]  SW,
   input  logic        insert,
   input  logic        commit,
   output logic [31:0] in_data,
   output logic        in_ack,
   output logic        out_ack,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7
);

   localparam int unsigned DB_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned NKEY   = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NDIG   = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   // Active-low segment pattern (bit0 = a ... bit6 = g) for one hex digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Key path state: bit 0 = insert, bit 1 = commit (both active-low raw keys).
   logic [NKEY-1:0] key_raw;
   logic [NKEY-1:0] sync1;
   logic [NKEY-1:0] sync2;
   logic [NKEY-1:0] lvl;
   logic [NKEY-1:0] lvl_d;
   logic [NKEY-1:0] press;
   logic [DB_W-1:0] db_cnt [NKEY];

   logic ins_ev;
   logic com_ev;

   assign key_raw = {commit, insert};
   assign ins_ev  = press[0];
   assign com_ev  = press[1];

   // Synchronize, debounce and turn accepted 1->0 transitions into one-cycle press pulses.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         sync1 <= '1;
         sync2 <= '1;
         lvl   <= '1;
         lvl_d <= '1;
         press <= '0;
         for (int k = 0; k < NKEY; k++) begin
            db_cnt[k] <= '0;
         end
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         lvl_d <= lvl;
         press <= lvl_d & ~lvl;
         for (int k = 0; k < NKEY; k++) begin
            if (sync2[k] != lvl[k]) begin
               if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  lvl[k]    <= sync2[k];
                  db_cnt[k] <= '0;
               end else begin
                  db_cnt[k] <= db_cnt[k] + DB_W'(1);
               end
            end else begin
               db_cnt[k] <= '0;
            end
         end
      end
   end

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] disp_reg;
   logic [DATA_W-1:0] disp_nxt;
   logic              rearm;
   logic              rearm_nxt;
   logic [DATA_W-1:0] in_data_nxt;
   logic              in_ack_nxt;
   logic              out_ack_nxt;
   logic [DATA_W-1:0] show_nxt;
   logic [6:0]        hex_q [NDIG];

   // Handshake FSM registers plus registered segment outputs.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         acc      <= '0;
         cnt      <= '0;
         disp_reg <= '0;
         rearm    <= 1'b1;
         in_data  <= '0;
         in_ack   <= 1'b0;
         out_ack  <= 1'b0;
         busy     <= 1'b0;
         for (int i = 0; i < NDIG; i++) begin
            hex_q[i] <= 7'b1000000;
         end
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         disp_reg <= disp_nxt;
         rearm    <= rearm_nxt;
         in_data  <= in_data_nxt;
         in_ack   <= in_ack_nxt;
         out_ack  <= out_ack_nxt;
         busy     <= (state_nxt == S_COLLECT);
         for (int i = 0; i < NDIG; i++) begin
            hex_q[i] <= seg7(show_nxt[4*i +: 4]);
         end
      end
   end

   // Next-state, accumulator and handshake decisions.
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      cnt_inc     = cnt + CNT_W'(1);
      disp_nxt    = disp_reg;
      rearm_nxt   = rearm;
      in_data_nxt = in_data;
      in_ack_nxt  = 1'b0;
      out_ack_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            // A request must drop before a new collection may start.
            if (!in_req) begin
               rearm_nxt = 1'b1;
            end
            if (out_req) begin
               disp_nxt    = out_data;
               out_ack_nxt = 1'b1;
            end else if (in_req && rearm) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (!in_req) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               if (ins_ev) begin
                  acc_nxt = {acc[DATA_W-5:0], SW};
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNT_W'(IN_NIBBLES)) begin
                     state_nxt = S_DONE;
                  end
               end
               if (com_ev) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            in_data_nxt = acc;
            in_ack_nxt  = 1'b1;
            rearm_nxt   = 1'b0;
            state_nxt   = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      show_nxt = (state_nxt == S_COLLECT) ? acc_nxt : disp_nxt;
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];
   assign HEX6 = hex_q[6];
   assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus pushes expected acks, a monitor pops them.
module tb_io_responder;

   localparam int unsigned DB  = 4;
   localparam int unsigned NIB = 8;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        in_req = 1'b0;
   logic        out_req = 1'b0;
   logic [31:0] out_data = '0;
   logic [3:0]  SW = '0;
   logic        insert = 1'b1;
   logic        commit = 1'b1;
   logic [31:0] in_data;
   logic        in_ack;
   logic        out_ack;
   logic        busy;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

   io_responder #(.DEBOUNCE_CYCLES(DB), .IN_NIBBLES(NIB)) dut (
      .CLK(CLK), .reset(reset), .in_req(in_req), .out_req(out_req),
      .out_data(out_data), .SW(SW), .insert(insert), .commit(commit),
      .in_data(in_data), .in_ack(in_ack), .out_ack(out_ack), .busy(busy),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_in;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_in = '0;
   logic [31:0] disp_model = '0;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   wire [55:0] hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   // Expected display for a 32-bit value, HEX0 holding the least-significant digit.
   function automatic logic [55:0] exp_hex(input logic [31:0] v);
      logic [55:0] r;
      logic [31:0] t;
      t = v;
      for (int i = 0; i < 8; i++) begin
         r[7*i +: 7] = seg_tab[t % 16];
         t = t / 16;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Monitor: every ack must match the oldest expected response.
   always @(negedge CLK) begin
      if (reset) begin
         if (out_ack) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out_ack: got out_ack=1 expected none at %0t", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_kind_out", 64'(0), 64'(e.is_in));
               chk("out_hex", 64'(hex_all), 64'(exp_hex(e.data)));
            end
         end
         if (in_ack) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_in_ack: got in_ack=1 in_data=%h expected none at %0t", in_data, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_kind_in", 64'(1), 64'(e.is_in));
               chk("in_data", 64'(in_data), 64'(e.data));
               chk("busy_at_in_ack", 64'(busy), 64'(0));
            end
         end
      end
   end

   task automatic push_exp(input bit is_in, input logic [31:0] d);
      exp_t e;
      e.is_in = is_in;
      e.data  = d;
      exp_q.push_back(e);
   endtask

   // Hold the selected keys low for len cycles, then release and let the level settle.
   task automatic key_act(input logic [3:0] nib, input bit ins, input bit com, input int len);
      SW = nib;
      if (ins) insert = 1'b0;
      if (com) commit = 1'b0;
      tick(len);
      insert = 1'b1;
      commit = 1'b1;
      tick(12);
   endtask

   task automatic do_out(input logic [31:0] d, input int n, input bit with_in);
      out_data = d;
      out_req  = 1'b1;
      in_req   = with_in;
      for (int i = 0; i < n; i++) push_exp(1'b0, d);
      tick(n);
      out_req = 1'b0;
      in_req  = 1'b0;
      disp_model = d;
      tick(2);
      chk("busy_after_out", 64'(busy), 64'(0));
      chk("hex_after_out", 64'(hex_all), 64'(exp_hex(d)));
   endtask

   // mode 1: last nibble pressed together with commit; mode 2: separate commit press.
   task automatic do_input(input int n, input logic [31:0] nibs, input int mode);
      logic [31:0] val;
      logic [3:0]  nib;
      bit          last;
      in_req = 1'b1;
      tick(2);
      chk("busy_collect", 64'(busy), 64'(1));
      chk("hex_cleared", 64'(hex_all), 64'(exp_hex(32'h0)));
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
         nib  = 4'((nibs >> (4 * (n - 1 - i))) % 16);
         val  = val * 32'd16 + 32'(nib);
         last = (i == n - 1);
         if (last && (n == NIB || mode == 1)) begin
            push_exp(1'b1, val);
            key_act(nib, 1'b1, (mode == 1) && (n < NIB), int'($urandom_range(5, 12)));
            chk("hex_idle_after_done", 64'(hex_all), 64'(exp_hex(disp_model)));
         end else begin
            key_act(nib, 1'b1, 1'b0, int'($urandom_range(5, 12)));
            chk("hex_acc", 64'(hex_all), 64'(exp_hex(val)));
         end
      end
      if (n < NIB && !(mode == 1 && n > 0)) begin
         push_exp(1'b1, val);
         key_act(4'h0, 1'b0, 1'b1, int'($urandom_range(5, 12)));
      end
      last_in = val;
      tick(3);
      chk("rearm_block", 64'(busy), 64'(0));
      chk("in_data_hold", 64'(in_data), 64'(last_in));
      in_req = 1'b0;
      tick(2);
   endtask

   initial begin
      int n;
      int mode;
      logic [31:0] v;

      tick(3);
      chk("rst_in_data", 64'(in_data), 64'(0));
      chk("rst_in_ack", 64'(in_ack), 64'(0));
      chk("rst_out_ack", 64'(out_ack), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_hex", 64'(hex_all), 64'(exp_hex(32'h0)));
      reset = 1'b1;
      tick(2);

      // Output with a simultaneous input request: output wins, nothing collects.
      do_out(32'h1234ABCD, 1, 1'b1);
      chk("hex7_is_1", 64'(HEX7), 64'(7'b1111001));
      chk("hex0_is_d", 64'(HEX0), 64'(7'b0100001));
      do_out($urandom, 3, 1'b0);

      do_input(8, 32'h12345678, 0);
      do_input(2, 32'h000000A5, 2);

      // Debounce: a 2-cycle glitch appends nothing, a 10-cycle press appends one nibble.
      in_req = 1'b1;
      tick(2);
      key_act(4'h7, 1'b1, 1'b0, 10);
      chk("hex_first_nib", 64'(hex_all), 64'(exp_hex(32'h7)));
      SW = 4'hF;
      insert = 1'b0;
      tick(2);
      insert = 1'b1;
      tick(14);
      chk("glitch_ignored", 64'(hex_all), 64'(exp_hex(32'h7)));
      key_act(4'h3, 1'b1, 1'b0, 10);
      chk("hex_second_nib", 64'(hex_all), 64'(exp_hex(32'h73)));
      push_exp(1'b1, 32'h73);
      key_act(4'h0, 1'b0, 1'b1, 6);
      last_in = 32'h73;
      in_req = 1'b0;
      tick(2);

      do_input(0, 32'h0, 2);
      do_input(3, $urandom, 1);

      for (int t = 0; t < 6; t++) begin
         n    = int'($urandom_range(0, NIB));
         mode = int'($urandom_range(1, 2));
         do_input(n, $urandom, mode);
         do_out($urandom, int'($urandom_range(1, 3)), 1'b0);
      end

      // Abort: dropping the request mid-collection gives no ack and keeps in_data.
      in_req = 1'b1;
      tick(2);
      v = 32'h0;
      for (int i = 0; i < 3; i++) begin
         logic [3:0] nb;
         nb = 4'($urandom_range(0, 15));
         v  = v * 32'd16 + 32'(nb);
         key_act(nb, 1'b1, 1'b0, 8);
      end
      chk("hex_before_abort", 64'(hex_all), 64'(exp_hex(v)));
      in_req = 1'b0;
      tick(3);
      chk("busy_after_abort", 64'(busy), 64'(0));
      chk("in_data_after_abort", 64'(in_data), 64'(last_in));
      chk("hex_after_abort", 64'(hex_all), 64'(exp_hex(disp_model)));
      do_out($urandom, 1, 1'b0);

      // Asynchronous reset in the middle of a collection.
      in_req = 1'b1;
      tick(2);
      key_act(4'h9, 1'b1, 1'b0, 8);
      key_act(4'hE, 1'b1, 1'b0, 8);
      @(posedge CLK);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_in_data", 64'(in_data), 64'(0));
      chk("midrst_in_ack", 64'(in_ack), 64'(0));
      chk("midrst_out_ack", 64'(out_ack), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_hex", 64'(hex_all), 64'(exp_hex(32'h0)));
      disp_model = 32'h0;
      last_in    = 32'h0;
      in_req = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);

      do_input(int'($urandom_range(1, NIB)), $urandom, 2);

      tick(5);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_responder.md
# io_responder

Device-side responder for the processor's IN/OUT instruction handshake. It answers input requests by assembling a 32-bit value from the 4-bit switches, one nibble per debounced `insert` press. It answers output requests by latching the 32-bit value and showing it as eight hex digits on the seven-segment displays. It sits between the processor core (`input_flag`, `output_flag`, `ReadData1`, `user_input`) and the board switches, keys and HEX displays.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a key level is accepted.
- `IN_NIBBLES`, default 8: number of `insert` presses that auto-complete an input (1..8).

Ports:
- `CLK`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_req`, in, 1: processor requests input; level, held until `in_ack`.
- `out_req`, in, 1: processor requests output; level.
- `out_data`, in, 32: value to display; sampled when the output is accepted.
- `SW`, in, 4: nibble source.
- `insert`, in, 1: raw key, active-low; appends a nibble.
- `commit`, in, 1: raw key, active-low; completes the input early.
- `in_data`, out, 32: assembled input value.
- `in_ack`, out, 1: one-cycle pulse; `in_data` is valid.
- `out_ack`, out, 1: one-cycle pulse; `out_data` has been latched.
- `busy`, out, 1: high while in COLLECT.
- `HEX0`..`HEX7`, out, 7 each: active-low segments, bit0 = a … bit6 = g. HEX0 is the least-significant digit.

## Operation
- Key path, identical for `insert` and `commit`:
  - 2-FF synchronizer, then a debounce counter.
  - The accepted level changes only after the raw level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press event is a one-cycle pulse on an accepted 1→0 transition. Accepted level resets to 1.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE, `out_req`=1: latch `out_data` into `disp_reg` and pulse `out_ack`. FSM stays in IDLE. `out_req` has priority over `in_req` in the same cycle.
  - `out_req` held high latches again each cycle, giving an `out_ack` every cycle.
  - IDLE, `in_req`=1, `out_req`=0, `rearm`=1: clear `acc` and `cnt`, go to COLLECT.
  - COLLECT, insert event: `acc <= {acc[27:0], SW}`, `cnt <= cnt+1`. If the new `cnt` equals `IN_NIBBLES`, go to DONE.
  - COLLECT, commit event: go to DONE. A commit with `cnt`=0 yields 0.
  - Insert and commit events in the same cycle: the nibble is appended, then the FSM goes to DONE.
  - COLLECT, `in_req` falls: abort to IDLE, clear `acc`, leave `in_data` unchanged, no `in_ack`.
  - DONE: `in_data <= acc`, pulse `in_ack`, clear `rearm`, go to IDLE.
  - `rearm` sets again when `in_req`=0 in IDLE. This prevents a stale request from restarting collection.
- Key events outside COLLECT are discarded.
- Display:
  - In COLLECT, digits show `acc`.
  - Otherwise, digits show `disp_reg`.
  - Digit encoding is standard hex 0-F, e.g. 0 = 1000000, 8 = 0000000, F = 0001110.

## Timing
- Reset values:
  - `in_data`=0, `in_ack`=0, `out_ack`=0, `busy`=0.
  - `acc`=0, `cnt`=0, `disp_reg`=0, `rearm`=1, FSM=IDLE.
  - All HEX = 1000000.
- A reset assertion mid-COLLECT returns every register to its reset value immediately.
- Output latency: `out_req` high at edge k gives `out_ack` and updated HEX after edge k+1.
- Input latency:
  - A raw key falling edge gives a press event `DEBOUNCE_CYCLES`+3 cycles later.
  - `acc` updates on the next edge.
  - The last accepted event gives DONE after one edge, then `in_ack` and `in_data` valid after the following edge. `in_ack` is high for exactly one cycle.
- `in_data` holds its value until the next DONE.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no event.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `IN_NIBBLES`=8.
- Reset check: assert `reset`=0 mid-run → all outputs take reset values within the same cycle, without waiting for a clock edge. HEX0..7 = 1000000.
- Output request: `out_req` pulse with `out_data`=0x1234ABCD → one `out_ack`, HEX7..HEX0 show 1,2,3,4,A,b,C,d.
  - With `in_req` also high in that cycle → no collection starts.
- Full input: `in_req`=1, then 8 clean presses with `SW`=1..8 → one `in_ack`, `in_data`=0x12345678.
  - `busy` falls the cycle DONE is entered.
- Early commit: presses with `SW`=0xA, then 0x5, then commit → `in_data`=0x000000A5, single `in_ack`.
- Debounce: a 2-cycle low glitch on `insert` during COLLECT → `acc` unchanged. A 10-cycle press → exactly one nibble appended.
- Abort and rearm:
  - Drop `in_req` after 3 presses → FSM returns to IDLE, no `in_ack`, `in_data` keeps its old value.
  - Hold `in_req` high after an `in_ack` → no new COLLECT until `in_req` has been low for at least one cycle.
